multi_cycle_control: RTL and testbench
======================================

Name: multi_cycle_control

Overview:
- Sequencing control unit for the multi-cycle RV32I core. Counterpart of the single-cycle opcode decoder.
- Instead of decoding one opcode into one static control word, it steps a state machine through IF/ID/EX/MEM/WB. It drives per-cycle datapath and memory enables, and waits on a memory ready handshake.
- Sits between the instruction register (opcode source) and the shared datapath: ALU muxes, register file, PC, unified memory.

Parameters:
- none; opcodes come from opcodes.v, state and mux encodings from the shared control include.

Ports:
- clk  input  1  core clock, all state updates on posedge
- reset  input  1  synchronous, active-high; forces state IF
- opcode  input  7  inst[6:0] from instruction register; stable from ID onward
- bcond  input  1  branch comparison result from ALU, valid in EX of BRANCH
- mem_ready  input  1  memory completes current read/write this cycle
- pc_write  output  1  load PC this cycle
- pc_source  output  1  0: ALU result, 1: ALUOut register
- i_or_d  output  1  memory address: 0 PC, 1 ALUOut
- mem_read  output  1  memory read request
- mem_write  output  1  memory write request
- ir_write  output  1  latch instruction register
- alu_src_a  output  1  0 PC, 1 reg A
- alu_src_b  output  2  00 reg B, 01 const 4, 10 immediate
- alu_op  output  2  00 add, 01 branch compare, 10 funct-decoded
- reg_write  output  1  register file write enable
- mem_to_reg  output  1  rd data from MDR
- pc_to_reg  output  1  rd data = ALU result (PC+4); has priority over mem_to_reg
- is_ecall  output  1  ECALL being retired
- instr_done  output  1  one-cycle pulse when an instruction's final PC update occurs

Behaviour:
- Clock, reset: single clock clk; reset is synchronous, active-high.
  - Reset asserted: next state IF, regardless of the current state, including mid-memory wait.
  - While reset=1, all outputs are forced to 0.
- Outputs are combinational from state, opcode, bcond and mem_ready. Every output not listed for a state is 0.
- IF: i_or_d=0, mem_read=1, ir_write=mem_ready.
  - mem_ready=0: hold in IF, keep mem_read=1.
  - mem_ready=1: go to ID.
- ID:
  - ECALL: alu_src_a=0, alu_src_b=01, alu_op=00, pc_write=1, pc_source=0, is_ecall=1, instr_done=1; go to IF.
  - Any other opcode: alu_src_a=0, alu_src_b=10, alu_op=00 (PC+imm into ALUOut); go to EX.
- EX, by opcode:
  - ARITHMETIC: a=1, b=00, op=10; go to WB.
  - ARITHMETIC_IMM: a=1, b=10, op=10; go to WB.
  - LOAD/STORE: a=1, b=10, op=00; go to MEM.
  - BRANCH: a=1, b=00, op=01.
    - bcond=1: pc_write=1, pc_source=1, instr_done=1; go to IF.
    - bcond=0: go to WB.
  - JAL: a=0, b=01, op=00, reg_write=1, pc_to_reg=1, pc_write=1, pc_source=1, instr_done=1; go to IF.
  - JALR: a=1, b=10, op=00 (target into ALUOut); go to WB.
  - Unknown opcode: no enables; go to WB (treated as NOP).
- MEM: i_or_d=1 throughout.
  - LOAD: mem_read=1; on mem_ready go to WB, else hold.
  - STORE: mem_write=1, held until mem_ready. In the mem_ready cycle: a=0, b=01, op=00, pc_write=1, pc_source=0, instr_done=1; go to IF.
- WB: a=0, b=01, op=00, pc_write=1, instr_done=1; go to IF.
  - pc_source=1 for JALR, 0 otherwise (PC+4).
  - reg_write=1 for ARITHMETIC, ARITHMETIC_IMM, LOAD, JALR; 0 for not-taken BRANCH and unknown opcodes.
  - mem_to_reg=1 for LOAD only; pc_to_reg=1 for JALR only.
- Boundary cases:
  - mem_write and mem_read are never both 1.
  - reg_write and pc_write never fire for a store before mem_ready.
  - Exactly one instr_done pulse per instruction.
  - An opcode change while in EX/MEM/WB must not occur; the controller still uses the current opcode without holding a copy.
- Latency with mem_ready tied 1, in cycles:
  - R/I: 4
  - LOAD: 5
  - STORE: 4
  - BRANCH taken: 3; not taken: 4
  - JAL: 3
  - JALR: 4
  - ECALL: 2
  - Each cycle mem_ready is low adds one cycle.

Decomposition:
- opcodes.v (existing) supplies the opcode constants.
- New shared include control_defs.v holds:
  - state encoding: IF=0, ID=1, EX=2, MEM=3, WB=4, 3 bits
  - alu_src_b codes and alu_op codes
- Single module; no sub-module. The state register and the output/next-state logic live in two always blocks.

Test Plan:
- Reset 2 cycles, then ARITHMETIC with mem_ready=1 -> states IF,ID,EX,WB. reg_write=1 only in cycle 4, pc_write+instr_done only in cycle 4, next cycle IF with mem_read=1.
- LOAD, mem_ready low 3 cycles in MEM -> mem_read=1, i_or_d=1 held 4 cycles. WB has reg_write=1, mem_to_reg=1. Total 8 cycles.
- BRANCH with bcond=1 -> pc_write=1, pc_source=1 in EX (cycle 3). With bcond=0 -> no pc_write in EX, WB pc_source=0, reg_write=0.
- JAL then JALR:
  - JAL EX: reg_write=pc_to_reg=pc_write=pc_source=1.
  - JALR EX: a=1, b=10, no writes; WB: pc_source=1, pc_to_reg=1.
- STORE, mem_ready=0 for 2 cycles -> mem_write=1 with pc_write=0 in those cycles. Ready cycle: mem_write=1, pc_write=1, instr_done=1.
- Reset asserted during MEM wait of a LOAD -> all outputs 0 during reset. After release state IF, no reg_write ever issued for the aborted load.
- ECALL (7'b1110011) -> ID: is_ecall=1, pc_write=1, instr_done=1, b=01; next state IF.

Source files
------------

// File: rtl/multi_cycle_control_pkg.sv
// rtl/multi_cycle_control_pkg.sv - opcode, state and mux encodings shared by the multi-cycle controller
package multi_cycle_control_pkg;

  // RV32I major opcodes recognised by the sequencer
  localparam logic [6:0] OP_ARITHMETIC     = 7'b0110011;
  localparam logic [6:0] OP_ARITHMETIC_IMM = 7'b0010011;
  localparam logic [6:0] OP_LOAD           = 7'b0000011;
  localparam logic [6:0] OP_STORE          = 7'b0100011;
  localparam logic [6:0] OP_BRANCH         = 7'b1100011;
  localparam logic [6:0] OP_JAL            = 7'b1101111;
  localparam logic [6:0] OP_JALR           = 7'b1100111;
  localparam logic [6:0] OP_ECALL          = 7'b1110011;

  // Sequencer states; encoding is shared with datapath debug views
  typedef enum logic [2:0] {
    ST_IF  = 3'd0,
    ST_ID  = 3'd1,
    ST_EX  = 3'd2,
    ST_MEM = 3'd3,
    ST_WB  = 3'd4
  } state_t;

  // ALU operand B select
  localparam logic [1:0] ALU_B_REG  = 2'b00;
  localparam logic [1:0] ALU_B_FOUR = 2'b01;
  localparam logic [1:0] ALU_B_IMM  = 2'b10;

  // ALU operation class
  localparam logic [1:0] ALU_OP_ADD    = 2'b00;
  localparam logic [1:0] ALU_OP_BRANCH = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT  = 2'b10;

  // One cycle's worth of datapath and memory control
  typedef struct packed {
    logic       pc_write;
    logic       pc_source;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       reg_write;
    logic       mem_to_reg;
    logic       pc_to_reg;
    logic       is_ecall;
    logic       instr_done;
  } ctrl_t;

  // Control word with only the ALU operand/operation fields set
  function automatic ctrl_t alu_setup(input logic src_a, input logic [1:0] src_b,
                                      input logic [1:0] op);
    ctrl_t c;
    c           = '0;
    c.alu_src_a = src_a;
    c.alu_src_b = src_b;
    c.alu_op    = op;
    return c;
  endfunction

  // Final step of an instruction: PC <- PC+4 (or ALUOut) and retire
  function automatic ctrl_t retire_setup(input logic from_aluout);
    ctrl_t c;
    c            = alu_setup(1'b0, ALU_B_FOUR, ALU_OP_ADD);
    c.pc_write   = 1'b1;
    c.pc_source  = from_aluout;
    c.instr_done = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/multi_cycle_control.sv
// rtl/multi_cycle_control.sv - IF/ID/EX/MEM/WB sequencer for the multi-cycle RV32I core
module multi_cycle_control
  import multi_cycle_control_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic       bcond,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_source,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       reg_write,
  output logic       mem_to_reg,
  output logic       pc_to_reg,
  output logic       is_ecall,
  output logic       instr_done
);

  state_t state;
  state_t next_state;
  ctrl_t  ctrl;

  // State register; reset always returns to fetch, even mid memory wait
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IF;
    end else begin
      state <= next_state;
    end
  end

  // Per-state control word and next state; opcode is read live, never copied
  always_comb begin
    ctrl       = '0;
    next_state = ST_IF;
    unique case (state)
      ST_IF: begin
        ctrl.i_or_d   = 1'b0;
        ctrl.mem_read = 1'b1;
        ctrl.ir_write = mem_ready;
        next_state    = mem_ready ? ST_ID : ST_IF;
      end
      ST_ID: begin
        if (opcode == OP_ECALL) begin
          ctrl          = retire_setup(1'b0);
          ctrl.is_ecall = 1'b1;
          next_state    = ST_IF;
        end else begin
          // Speculative PC+imm into ALUOut for branches and JAL
          ctrl       = alu_setup(1'b0, ALU_B_IMM, ALU_OP_ADD);
          next_state = ST_EX;
        end
      end
      ST_EX: begin
        case (opcode)
          OP_ARITHMETIC: begin
            ctrl       = alu_setup(1'b1, ALU_B_REG, ALU_OP_FUNCT);
            next_state = ST_WB;
          end
          OP_ARITHMETIC_IMM: begin
            ctrl       = alu_setup(1'b1, ALU_B_IMM, ALU_OP_FUNCT);
            next_state = ST_WB;
          end
          OP_LOAD, OP_STORE: begin
            ctrl       = alu_setup(1'b1, ALU_B_IMM, ALU_OP_ADD);
            next_state = ST_MEM;
          end
          OP_BRANCH: begin
            ctrl = alu_setup(1'b1, ALU_B_REG, ALU_OP_BRANCH);
            if (bcond) begin
              // Taken: target already sits in ALUOut from ID
              ctrl.pc_write   = 1'b1;
              ctrl.pc_source  = 1'b1;
              ctrl.instr_done = 1'b1;
              next_state      = ST_IF;
            end else begin
              next_state = ST_WB;
            end
          end
          OP_JAL: begin
            // Link PC+4 and jump to ALUOut in the same cycle
            ctrl           = retire_setup(1'b1);
            ctrl.reg_write = 1'b1;
            ctrl.pc_to_reg = 1'b1;
            next_state     = ST_IF;
          end
          OP_JALR: begin
            ctrl       = alu_setup(1'b1, ALU_B_IMM, ALU_OP_ADD);
            next_state = ST_WB;
          end
          default: begin
            // Unrecognised opcode retires as a NOP through WB
            next_state = ST_WB;
          end
        endcase
      end
      ST_MEM: begin
        if (opcode == OP_STORE) begin
          if (mem_ready) begin
            ctrl = retire_setup(1'b0);
          end
          ctrl.i_or_d    = 1'b1;
          ctrl.mem_write = 1'b1;
          next_state     = mem_ready ? ST_IF : ST_MEM;
        end else begin
          ctrl.i_or_d   = 1'b1;
          ctrl.mem_read = 1'b1;
          next_state    = mem_ready ? ST_WB : ST_MEM;
        end
      end
      ST_WB: begin
        ctrl = retire_setup(opcode == OP_JALR);
        ctrl.reg_write  = (opcode == OP_ARITHMETIC) || (opcode == OP_ARITHMETIC_IMM) ||
                          (opcode == OP_LOAD) || (opcode == OP_JALR);
        ctrl.mem_to_reg = (opcode == OP_LOAD);
        ctrl.pc_to_reg  = (opcode == OP_JALR);
        next_state      = ST_IF;
      end
      default: begin
        next_state = ST_IF;
      end
    endcase
    if (reset) begin
      ctrl = '0;
    end
  end

  assign pc_write   = ctrl.pc_write;
  assign pc_source  = ctrl.pc_source;
  assign i_or_d     = ctrl.i_or_d;
  assign mem_read   = ctrl.mem_read;
  assign mem_write  = ctrl.mem_write;
  assign ir_write   = ctrl.ir_write;
  assign alu_src_a  = ctrl.alu_src_a;
  assign alu_src_b  = ctrl.alu_src_b;
  assign alu_op     = ctrl.alu_op;
  assign reg_write  = ctrl.reg_write;
  assign mem_to_reg = ctrl.mem_to_reg;
  assign pc_to_reg  = ctrl.pc_to_reg;
  assign is_ecall   = ctrl.is_ecall;
  assign instr_done = ctrl.instr_done;

endmodule

// File: tb/tb_multi_cycle_control.sv
// tb/tb_multi_cycle_control.sv - self-checking bench for multi_cycle_control
module tb_multi_cycle_control;

  localparam logic [6:0] ARI  = 7'b0110011;
  localparam logic [6:0] IMM  = 7'b0010011;
  localparam logic [6:0] LD   = 7'b0000011;
  localparam logic [6:0] ST   = 7'b0100011;
  localparam logic [6:0] BR   = 7'b1100011;
  localparam logic [6:0] JAL  = 7'b1101111;
  localparam logic [6:0] JALR = 7'b1100111;
  localparam logic [6:0] ECL  = 7'b1110011;
  localparam logic [6:0] UNK  = 7'b0110111;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] opcode;
  logic       bcond;
  logic       mem_ready;
  logic       pc_write, pc_source, i_or_d, mem_read, mem_write, ir_write, alu_src_a;
  logic [1:0] alu_src_b, alu_op;
  logic       reg_write, mem_to_reg, pc_to_reg, is_ecall, instr_done;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [15:0] w;
    bit          fixed;
    bit          rdy;
  } step_t;

  step_t trace[$];

  multi_cycle_control dut (
    .clk(clk), .reset(reset), .opcode(opcode), .bcond(bcond), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_source(pc_source), .i_or_d(i_or_d), .mem_read(mem_read),
    .mem_write(mem_write), .ir_write(ir_write), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .reg_write(reg_write),
    .mem_to_reg(mem_to_reg), .pc_to_reg(pc_to_reg), .is_ecall(is_ecall),
    .instr_done(instr_done)
  );

  always #5 clk = ~clk;

  wire [15:0] outs = {pc_write, pc_source, i_or_d, mem_read, mem_write, ir_write, alu_src_a,
                      alu_src_b, alu_op, reg_write, mem_to_reg, pc_to_reg, is_ecall, instr_done};

  // Expected control word in the bench's own field order
  function automatic logic [15:0] cw(bit pcw, bit pcs, bit iod, bit mr, bit mw, bit irw,
                                     bit a, logic [1:0] b, logic [1:0] op, bit rw,
                                     bit m2r, bit p2r, bit ecl, bit done);
    return {pcw, pcs, iod, mr, mw, irw, a, b, op, rw, m2r, p2r, ecl, done};
  endfunction

  // Cycles from fetch to retire with memory always ready
  function automatic int base_latency(logic [6:0] opc, logic bc);
    case (opc)
      ECL:     return 2;
      JAL:     return 3;
      BR:      return bc ? 3 : 4;
      LD:      return 5;
      default: return 4;
    endcase
  endfunction

  function automatic void push(logic [15:0] w, bit fixed, bit rdy);
    step_t s;
    s.w = w; s.fixed = fixed; s.rdy = rdy;
    trace.push_back(s);
  endfunction

  // Reference: instruction class -> expected sequence of control words
  function automatic void build_trace(logic [6:0] opc, logic bc, int fs, int ms);
    bit wb_rw;
    trace.delete();
    for (int i = 0; i < fs; i++) push(cw(0,0,0,1,0,0,0,2'b00,2'b00,0,0,0,0,0), 1, 0);
    push(cw(0,0,0,1,0,1,0,2'b00,2'b00,0,0,0,0,0), 1, 1);
    if (opc == ECL) begin
      push(cw(1,0,0,0,0,0,0,2'b01,2'b00,0,0,0,1,1), 0, 0);
      return;
    end
    push(cw(0,0,0,0,0,0,0,2'b10,2'b00,0,0,0,0,0), 0, 0);
    case (opc)
      ARI:  push(cw(0,0,0,0,0,0,1,2'b00,2'b10,0,0,0,0,0), 0, 0);
      IMM:  push(cw(0,0,0,0,0,0,1,2'b10,2'b10,0,0,0,0,0), 0, 0);
      LD, ST: push(cw(0,0,0,0,0,0,1,2'b10,2'b00,0,0,0,0,0), 0, 0);
      BR:   push(cw(bc,bc,0,0,0,0,1,2'b00,2'b01,0,0,0,0,bc), 0, 0);
      JAL:  push(cw(1,1,0,0,0,0,0,2'b01,2'b00,1,0,1,0,1), 0, 0);
      JALR: push(cw(0,0,0,0,0,0,1,2'b10,2'b00,0,0,0,0,0), 0, 0);
      default: push(16'h0, 0, 0);
    endcase
    if (opc == JAL || (opc == BR && bc)) return;
    if (opc == ST) begin
      for (int i = 0; i < ms; i++) push(cw(0,0,1,0,1,0,0,2'b00,2'b00,0,0,0,0,0), 1, 0);
      push(cw(1,0,1,0,1,0,0,2'b01,2'b00,0,0,0,0,1), 1, 1);
      return;
    end
    if (opc == LD) begin
      for (int i = 0; i < ms; i++) push(cw(0,0,1,1,0,0,0,2'b00,2'b00,0,0,0,0,0), 1, 0);
      push(cw(0,0,1,1,0,0,0,2'b00,2'b00,0,0,0,0,0), 1, 1);
    end
    wb_rw = (opc == ARI || opc == IMM || opc == LD || opc == JALR);
    push(cw(1, opc == JALR, 0,0,0,0,0,2'b01,2'b00, wb_rw, opc == LD, opc == JALR, 0, 1), 0, 0);
  endfunction

  // Run one instruction from IF, comparing every cycle and its retire latency
  task automatic test_instr(input string name, input logic [6:0] opc, input logic bc,
                            input int fs, input int ms);
    int done_cnt = 0;
    int done_at  = -1;
    int lat;
    build_trace(opc, bc, fs, ms);
    lat = base_latency(opc, bc) + fs + ((opc == LD || opc == ST) ? ms : 0);
    for (int i = 0; i < trace.size(); i++) begin
      opcode    = opc;
      bcond     = (opc == BR) ? bc : 1'($urandom_range(0, 1));
      mem_ready = trace[i].fixed ? trace[i].rdy : 1'($urandom_range(0, 1));
      @(negedge clk);
      total++;
      if (outs !== trace[i].w) begin
        bad++;
        $display("FAIL %s cycle %0d: got=%h expected=%h", name, i + 1, outs, trace[i].w);
      end
      if (instr_done === 1'b1) begin
        done_cnt++;
        if (done_at < 0) done_at = i + 1;
      end
      @(posedge clk);
      #1;
    end
    total++;
    if (done_cnt !== 1 || done_at !== lat) begin
      bad++;
      $display("FAIL %s latency: pulses=%0d at=%0d expected 1 at %0d", name, done_cnt, done_at, lat);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      opcode = 7'($urandom); bcond = 1'($urandom_range(0, 1)); mem_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      total++;
      if (outs !== 16'h0) begin
        bad++;
        $display("FAIL reset cycle %0d: got=%h expected=0000", i, outs);
      end
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
  endtask

  task automatic test_arith();
    test_instr("arith", ARI, 1'b0, 0, 0);
    test_instr("arith_imm", IMM, 1'b0, 0, 0);
  endtask

  task automatic test_load_stall();
    test_instr("load_stall3", LD, 1'b0, 0, 3);
  endtask

  task automatic test_branch();
    test_instr("branch_taken", BR, 1'b1, 0, 0);
    test_instr("branch_not_taken", BR, 1'b0, 0, 0);
  endtask

  task automatic test_jal_jalr();
    test_instr("jal", JAL, 1'b0, 0, 0);
    test_instr("jalr", JALR, 1'b0, 0, 0);
  endtask

  task automatic test_store_stall();
    test_instr("store_stall2", ST, 1'b0, 0, 2);
  endtask

  task automatic test_ecall();
    test_instr("ecall", ECL, 1'b0, 0, 0);
    test_instr("unknown_op", UNK, 1'b0, 1, 0);
  endtask

  task automatic test_reset_mid_load();
    opcode = LD; bcond = 1'b0; mem_ready = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    mem_ready = 1'b0;
    @(negedge clk);
    total++;
    if (outs !== cw(0,0,1,1,0,0,0,2'b00,2'b00,0,0,0,0,0)) begin
      bad++;
      $display("FAIL abort_load mem_wait: got=%h", outs);
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      mem_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      total++;
      if (outs !== 16'h0) begin
        bad++;
        $display("FAIL abort_load reset cycle %0d: got=%h expected=0000", i, outs);
      end
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
    mem_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      total++;
      if (outs !== cw(0,0,0,1,0,0,0,2'b00,2'b00,0,0,0,0,0)) begin
        bad++;
        $display("FAIL abort_load after_reset cycle %0d: got=%h expected IF wait", i, outs);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_back_to_back();
    logic [6:0] ops [9];
    ops = '{ARI, IMM, LD, ST, BR, JAL, JALR, ECL, UNK};
    for (int n = 0; n < 40; n++) begin
      test_instr("random", ops[$urandom_range(0, 8)], 1'($urandom_range(0, 1)),
                 int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
    end
  endtask

  initial begin
    reset = 1'b1; opcode = 7'h0; bcond = 1'b0; mem_ready = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_arith();
    test_load_stall();
    test_branch();
    test_jal_jalr();
    test_store_stall();
    test_reset_mid_load();
    test_ecall();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
